mips_multi_cycle_control: RTL and testbench

//  Moore FSM that drives the control inputs of the multi-cycle MIPS datapath (PC/IR/A-B/ALUOut regs,

---
 rtl/mips_ctrl_pkg.sv | 111 +++++++++++
 rtl/mips_alu_decoder.sv | 32 +++
 rtl/mips_multi_cycle_control.sv | 101 ++++++++++
 tb/tb_mips_multi_cycle_control.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module   : mips_ctrl_pkg
// Brief    : State, opcode/funct, ALU and control-word definitions for the
//            multi-cycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    localparam int c_STATE_W = 4;

    typedef enum logic [c_STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_ADDIEXEC = 4'd8,
        S_ADDIWB   = 4'd9,
        S_BRANCH   = 4'd10
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_NOR = 6'h27;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;
    localparam logic [3:0] c_ALU_SLT = 4'b0111;
    localparam logic [3:0] c_ALU_NOR = 4'b1100;

    localparam logic [1:0] c_SRCB_REG = 2'b00;
    localparam logic [1:0] c_SRCB_ONE = 2'b01;
    localparam logic [1:0] c_SRCB_IMM = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       cus;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       pc_src;
    } ctrl_t;

    // Moore control word for a state; alu_exec only matters in EXECUTE.
    // Unknown state codes yield an all-zero word.
    function automatic ctrl_t ctrl_for_state(input state_t s, input logic [3:0] alu_exec);
        ctrl_t c;
        c             = '0;
        c.alu_control = c_ALU_ADD;
        case (s)
            S_FETCH: begin
                c.ir_write  = 1'b1;
                c.alu_src_a = 1'b1;
                c.alu_src_b = c_SRCB_ONE;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = c_SRCB_IMM;
            end
            S_MEMADR:   c.alu_src_b = c_SRCB_IMM;
            S_MEMREAD:  c.iord = 1'b1;
            S_MEMWB:    c.reg_write = 1'b1;
            S_MEMWRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE:  c.alu_control = alu_exec;
            S_ALUWB: begin
                c.cus        = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_ADDIEXEC: c.alu_src_b = c_SRCB_IMM;
            S_ADDIWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_control = c_ALU_SUB;
                c.pc_src      = 1'b1;
            end
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_alu_decoder.sv
// ============================================================================
// Module   : mips_alu_decoder
// Brief    : R-type funct field to ALUControl mapping with legality flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_control,
    output logic       o_funct_ok
);

    always_comb begin
        o_alu_control = c_ALU_ADD;
        o_funct_ok    = 1'b1;
        case (i_funct)
            c_FN_ADD: o_alu_control = c_ALU_ADD;
            c_FN_SUB: o_alu_control = c_ALU_SUB;
            c_FN_AND: o_alu_control = c_ALU_AND;
            c_FN_OR:  o_alu_control = c_ALU_OR;
            c_FN_NOR: o_alu_control = c_ALU_NOR;
            c_FN_SLT: o_alu_control = c_ALU_SLT;
            default:  o_funct_ok    = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multi_cycle_control.sv
// ============================================================================
// Module   : mips_multi_cycle_control
// Brief    : Moore FSM sequencing the multi-cycle MIPS datapath control lines.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multi_cycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         funct_i,
    input  logic               zero_i,
    output logic               PCWrite,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               CUS,
    output logic [1:0]         ALUSrcB,
    output logic [3:0]         ALUControl,
    output logic               PCSrc,
    output logic [STATE_W-1:0] state_o,
    output logic               illegal_o
);

    state_t     r_state;
    ctrl_t      r_ctrl;
    state_t     w_next;
    logic       w_illegal;
    logic [3:0] w_alu_control;
    logic       w_funct_ok;

    mips_alu_decoder u_alu_decoder (
        .i_funct       (funct_i),
        .o_alu_control (w_alu_control),
        .o_funct_ok    (w_funct_ok)
    );

    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    c_OP_RTYPE: begin
                        if (w_funct_ok) w_next    = S_EXECUTE;
                        else            w_illegal = 1'b1;
                    end
                    c_OP_LW, c_OP_SW: w_next    = S_MEMADR;
                    c_OP_ADDI:        w_next    = S_ADDIEXEC;
                    c_OP_BEQ:         w_next    = S_BRANCH;
                    default:          w_illegal = 1'b1;
                endcase
            end
            S_MEMADR:   w_next = (opcode_i == c_OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ADDIEXEC: w_next = S_ADDIWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // The control word is registered alongside the state; its reset value is
    // the FETCH word so the first cycle after release already fetches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for_state(S_FETCH, c_ALU_ADD);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for_state(w_next, w_alu_control);
        end
    end

    // Outputs are masked while reset is held so no write can slip through.
    assign PCWrite    = reset & (r_ctrl.pc_write | ((r_state == S_BRANCH) & zero_i));
    assign IorD       = reset & r_ctrl.iord;
    assign MemWrite   = reset & r_ctrl.mem_write;
    assign IRWrite    = reset & r_ctrl.ir_write;
    assign MemtoReg   = reset & r_ctrl.mem_to_reg;
    assign RegWrite   = reset & r_ctrl.reg_write;
    assign ALUSrcA    = reset & r_ctrl.alu_src_a;
    assign CUS        = reset & r_ctrl.cus;
    assign ALUSrcB    = reset ? r_ctrl.alu_src_b   : 2'b00;
    assign ALUControl = reset ? r_ctrl.alu_control : 4'b0000;
    assign PCSrc      = reset & r_ctrl.pc_src;
    assign illegal_o  = reset & w_illegal;
    assign state_o    = STATE_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mips_multi_cycle_control.sv
// ============================================================================
// Module   : tb_mips_multi_cycle_control
// Brief    : Scoreboard bench for the multi-cycle MIPS control FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multi_cycle_control;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] SLT = 4'b0111;
    localparam logic [3:0] NOR = 4'b1100;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode_i;
    logic [5:0] funct_i;
    logic       zero_i;
    logic       PCWrite, IorD, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, CUS, PCSrc, illegal_o;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUControl;
    logic [3:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  q_st[$];
    logic [15:0] q_out[$];
    string       q_nm[$];

    logic [15:0] e_fetch, e_dec, e_dec_ill, e_madr, e_mrd, e_mwb, e_mwr, e_alwb, e_aexe, e_awb;

    always #5 clk = ~clk;

    mips_multi_cycle_control #(.STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode_i   (opcode_i),
        .funct_i    (funct_i),
        .zero_i     (zero_i),
        .PCWrite    (PCWrite),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .CUS        (CUS),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .PCSrc      (PCSrc),
        .state_o    (state_o),
        .illegal_o  (illegal_o)
    );

    logic [15:0] w_act;
    assign w_act = {PCWrite, IorD, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, CUS,
                    ALUSrcB, ALUControl, PCSrc, illegal_o};

    function automatic logic [15:0] mk(input logic pcw, iord, mw, irw, m2r, rw, sa, cus,
                                       input logic [1:0] sb, input logic [3:0] ac,
                                       input logic ps, il);
        return {pcw, iord, mw, irw, m2r, rw, sa, cus, sb, ac, ps, il};
    endfunction

    task automatic check(input string nm, input logic [19:0] act, input logic [19:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (state,outs)", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [3:0] st, input logic [15:0] ov);
        q_nm.push_back(nm);
        q_st.push_back(st);
        q_out.push_back(ov);
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode_i = op;
        funct_i  = fn;
        zero_i   = z;
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    initial begin : monitor
        string       nm;
        logic [3:0]  st;
        logic [15:0] ov;
        forever begin
            @(negedge clk);
            if (q_st.size() > 0) begin
                nm = q_nm.pop_front();
                st = q_st.pop_front();
                ov = q_out.pop_front();
                check(nm, {state_o, w_act}, {st, ov});
            end
        end
    end

    initial begin : driver
        e_fetch   = mk(1,0,0,1,0,0,1,0, 2'b01, ADD, 0,0);
        e_dec     = mk(0,0,0,0,0,0,1,0, 2'b10, ADD, 0,0);
        e_dec_ill = mk(0,0,0,0,0,0,1,0, 2'b10, ADD, 0,1);
        e_madr    = mk(0,0,0,0,0,0,0,0, 2'b10, ADD, 0,0);
        e_mrd     = mk(0,1,0,0,0,0,0,0, 2'b00, ADD, 0,0);
        e_mwb     = mk(0,0,0,0,0,1,0,0, 2'b00, ADD, 0,0);
        e_mwr     = mk(0,1,1,0,0,0,0,0, 2'b00, ADD, 0,0);
        e_alwb    = mk(0,0,0,0,1,1,0,1, 2'b00, ADD, 0,0);
        e_aexe    = mk(0,0,0,0,0,0,0,0, 2'b10, ADD, 0,0);
        e_awb     = mk(0,0,0,0,1,1,0,0, 2'b00, ADD, 0,0);

        reset = 1'b0;
        set_instr(6'h2B, 6'h00, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_held_outs", {state_o, w_act}, 20'h0);
        reset = 1'b1;
        #1;
        check("rel_fetch", {state_o, w_act}, {4'd0, e_fetch});

        // Drop reset in the middle of a store's MEMWRITE cycle.
        repeat (3) @(posedge clk);
        #2;
        check("sw_state_mwr", {16'd0, state_o}, 20'd5);
        check("sw_memwrite",  {19'd0, MemWrite}, 20'd1);
        reset = 1'b0;
        #1;
        check("rst_memwrite_drop", {19'd0, MemWrite}, 20'd0);
        check("rst_all_zero", {state_o, w_act}, 20'h0);
        @(posedge clk);
        #1;
        check("rst_edge_zero", {state_o, w_act}, 20'h0);
        reset = 1'b1;
        #1;
        check("rel2_irwrite", {19'd0, IRWrite}, 20'd1);
        check("rel2_pcwrite", {19'd0, PCWrite}, 20'd1);
        check("rel2_state",   {16'd0, state_o}, 20'd0);

        // lw
        set_instr(6'h23, 6'h00, 1'b0);
        push("lw_fetch", 4'd0, e_fetch); push("lw_dec", 4'd1, e_dec);
        push("lw_madr", 4'd2, e_madr);   push("lw_mrd", 4'd3, e_mrd);
        push("lw_mwb", 4'd4, e_mwb);
        run(5);

        // sw
        set_instr(6'h2B, 6'h00, 1'b0);
        push("sw_fetch", 4'd0, e_fetch); push("sw_dec", 4'd1, e_dec);
        push("sw_madr", 4'd2, e_madr);   push("sw_mwr", 4'd5, e_mwr);
        run(4);

        // R-type sub, slt, add, nor
        set_instr(6'h00, 6'h22, 1'b0);
        push("sub_fetch", 4'd0, e_fetch); push("sub_dec", 4'd1, e_dec);
        push("sub_exec", 4'd6, mk(0,0,0,0,0,0,0,0, 2'b00, SUB, 0,0));
        push("sub_wb", 4'd7, e_alwb);
        run(4);
        set_instr(6'h00, 6'h2A, 1'b0);
        push("slt_fetch", 4'd0, e_fetch); push("slt_dec", 4'd1, e_dec);
        push("slt_exec", 4'd6, mk(0,0,0,0,0,0,0,0, 2'b00, SLT, 0,0));
        push("slt_wb", 4'd7, e_alwb);
        run(4);
        set_instr(6'h00, 6'h20, 1'b0);
        push("add_fetch", 4'd0, e_fetch); push("add_dec", 4'd1, e_dec);
        push("add_exec", 4'd6, mk(0,0,0,0,0,0,0,0, 2'b00, ADD, 0,0));
        push("add_wb", 4'd7, e_alwb);
        run(4);
        set_instr(6'h00, 6'h27, 1'b0);
        push("nor_fetch", 4'd0, e_fetch); push("nor_dec", 4'd1, e_dec);
        push("nor_exec", 4'd6, mk(0,0,0,0,0,0,0,0, 2'b00, NOR, 0,0));
        push("nor_wb", 4'd7, e_alwb);
        run(4);

        // Illegal funct
        set_instr(6'h00, 6'h00, 1'b0);
        push("badfn_fetch", 4'd0, e_fetch); push("badfn_dec", 4'd1, e_dec_ill);
        run(2);

        // beq taken / not taken
        set_instr(6'h04, 6'h00, 1'b1);
        push("beqt_fetch", 4'd0, e_fetch); push("beqt_dec", 4'd1, e_dec);
        push("beqt_br", 4'd10, mk(1,0,0,0,0,0,0,0, 2'b00, SUB, 1,0));
        run(3);
        set_instr(6'h04, 6'h00, 1'b0);
        push("beqn_fetch", 4'd0, e_fetch); push("beqn_dec", 4'd1, e_dec);
        push("beqn_br", 4'd10, mk(0,0,0,0,0,0,0,0, 2'b00, SUB, 1,0));
        run(3);

        // Illegal opcode, then addi
        set_instr(6'h3F, 6'h20, 1'b0);
        push("badop_fetch", 4'd0, e_fetch); push("badop_dec", 4'd1, e_dec_ill);
        run(2);
        set_instr(6'h08, 6'h00, 1'b0);
        push("addi_fetch", 4'd0, e_fetch); push("addi_dec", 4'd1, e_dec);
        push("addi_exec", 4'd8, e_aexe);   push("addi_wb", 4'd9, e_awb);
        run(4);
        push("final_fetch", 4'd0, e_fetch);
        run(1);

        repeat (2) @(negedge clk);
        check("queue_drained", 20'(q_st.size()), 20'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
